// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh arbiter: state encoding,
// the power-up init byte table and the screen region geometry.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_INIT      = 3'd1,
        ST_IDLE      = 3'd2,
        ST_CMD_Y     = 3'd3,
        ST_CMD_X     = 3'd4,
        ST_FETCH     = 3'd5,
        ST_DATA      = 3'd6,
        ST_FIN       = 3'd7
    } state_t;

    localparam int         NUM_REGIONS    = 6;
    localparam int         INIT_LEN       = 6;
    localparam logic [7:0] CMD_SETX       = 8'h80;
    localparam logic [7:0] CMD_SETY       = 8'h40;
    localparam logic [6:0] FACE_X0        = 7'd0;
    localparam logic [6:0] FACE_WIDTH     = 7'd48;
    localparam logic [2:0] FACE_LAST_BANK = 3'd5;
    localparam logic [6:0] BAR_X0         = 7'd48;
    localparam logic [6:0] BAR_WIDTH      = 7'd36;

    // Init sequence: extended mode, Vop, temp coeff, bias, basic mode, normal display.
    function automatic logic [7:0] init_byte(input logic [2:0] idx, input logic [7:0] contrast);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h21;
            3'd1:    b = contrast;
            3'd2:    b = 8'h04;
            3'd3:    b = 8'h14;
            3'd4:    b = 8'h20;
            3'd5:    b = 8'h0C;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [6:0] region_x0(input logic [2:0] r);
        return (r == 3'd0) ? FACE_X0 : BAR_X0;
    endfunction

    function automatic logic [6:0] region_width(input logic [2:0] r);
        return (r == 3'd0) ? FACE_WIDTH : BAR_WIDTH;
    endfunction

    // Bar r occupies the single bank r-1; the face spans banks 0..5.
    function automatic logic [2:0] region_first_bank(input logic [2:0] r);
        return (r == 3'd0) ? 3'd0 : (r - 3'd1);
    endfunction

    function automatic logic [2:0] region_last_bank(input logic [2:0] r);
        return (r == 3'd0) ? FACE_LAST_BANK : (r - 3'd1);
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set bit of dirty at or after ptr,
// wrapping from region 5 back to region 0.
module rr_pick6
    import lcd_pkg::*;
(
    input  logic [5:0] dirty,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);

    logic [3:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest dirty region wins.
    always_comb begin
        valid  = 1'b0;
        idx    = 3'd0;
        cand_s = 4'd0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            cand_s = {1'b0, ptr} + 4'(k);
            if (cand_s >= 4'd6) begin
                cand_s = cand_s - 4'd6;
            end else begin
                cand_s = cand_s;
            end
            if (dirty[cand_s[2:0]]) begin
                valid = 1'b1;
                idx   = cand_s[2:0];
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/lcd_refresh_arbiter.sv
// Schedules all byte traffic to the 84x48 LCD SPI engine: reset pulse, init
// sequence, then round-robin redraw of dirty face/bar regions.
module lcd_refresh_arbiter
    import lcd_pkg::*;
#(
    parameter int         RST_CYCLES    = 4,
    parameter logic [7:0] CONTRAST      = 8'hB1,
    parameter int         REFRESH_TICKS = 0
) (
    input  logic       clk,
    input  logic       rst1,
    input  logic [3:0] face_in,
    input  logic [2:0] food_lvl,
    input  logic [2:0] sleep_lvl,
    input  logic [2:0] fun_lvl,
    input  logic [2:0] happy_lvl,
    input  logic [2:0] health_lvl,
    output logic [2:0] rd_region,
    output logic [2:0] rd_bank,
    output logic [6:0] rd_col,
    input  logic [7:0] rd_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       lcd_rst_n,
    output logic       busy,
    output logic       done
);

    state_t      state_r;
    logic [15:0] rst_cnt_r;
    logic [2:0]  init_idx_r;
    logic [2:0]  rr_ptr_r;
    logic [5:0]  dirty_r;
    logic [3:0]  prev_face_r;
    logic [14:0] prev_lvls_r;
    logic [31:0] refresh_cnt_r;

    logic [5:0]  change_s;
    logic [5:0]  clear_mask_s;
    logic        fill_all_s;
    logic        refresh_wrap_s;
    logic        accept_s;
    logic        pick_valid_s;
    logic [2:0]  pick_idx_s;
    logic [14:0] lvls_s;

    rr_pick6 u_pick (
        .dirty (dirty_r),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Change detection, grant clearing and all-dirty triggers.
    always_comb begin
        lvls_s         = {health_lvl, happy_lvl, fun_lvl, sleep_lvl, food_lvl};
        accept_s       = tx_valid & tx_ready;
        change_s       = 6'b000000;
        change_s[0]    = (face_in != prev_face_r);
        for (int i = 0; i < 5; i++) begin
            change_s[i+1] = (lvls_s[3*i +: 3] != prev_lvls_r[3*i +: 3]);
        end
        if ((state_r == ST_IDLE) && pick_valid_s) begin
            clear_mask_s = 6'b000001 << pick_idx_s;
        end else begin
            clear_mask_s = 6'b000000;
        end
        fill_all_s     = (state_r == ST_INIT) && accept_s && (init_idx_r == 3'(INIT_LEN - 1));
        refresh_wrap_s = (REFRESH_TICKS > 0) && (state_r == ST_IDLE)
                         && (refresh_cnt_r == 32'(REFRESH_TICKS - 1));
    end

    // Dirty bits and previous-value tracking; a set always beats a grant clear.
    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            dirty_r     <= 6'b000000;
            prev_face_r <= 4'd0;
            prev_lvls_r <= 15'd0;
        end else begin
            prev_face_r <= face_in;
            prev_lvls_r <= lvls_s;
            dirty_r     <= (dirty_r & ~clear_mask_s) | change_s
                           | ((fill_all_s || refresh_wrap_s) ? 6'b111111 : 6'b000000);
        end
    end

    // Periodic full-refresh counter, advancing only while idle.
    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            refresh_cnt_r <= 32'd0;
        end else if ((REFRESH_TICKS > 0) && (state_r == ST_IDLE)) begin
            refresh_cnt_r <= refresh_wrap_s ? 32'd0 : refresh_cnt_r + 32'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r;
        end
    end

    // Main sequencer: owns every registered output.
    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            state_r    <= ST_RST_PULSE;
            rst_cnt_r  <= 16'd0;
            init_idx_r <= 3'd0;
            rr_ptr_r   <= 3'd0;
            tx_valid   <= 1'b0;
            tx_byte    <= 8'h00;
            tx_dc      <= 1'b0;
            lcd_rst_n  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            rd_region  <= 3'd0;
            rd_bank    <= 3'd0;
            rd_col     <= 7'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_RST_PULSE: begin
                    if (rst_cnt_r == 16'(RST_CYCLES - 1)) begin
                        lcd_rst_n  <= 1'b1;
                        init_idx_r <= 3'd0;
                        tx_byte    <= init_byte(3'd0, CONTRAST);
                        tx_dc      <= 1'b0;
                        tx_valid   <= 1'b1;
                        state_r    <= ST_INIT;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + 16'd1;
                    end
                end
                ST_INIT: begin
                    if (accept_s && (init_idx_r == 3'(INIT_LEN - 1))) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (accept_s) begin
                        init_idx_r <= init_idx_r + 3'd1;
                        tx_byte    <= init_byte(init_idx_r + 3'd1, CONTRAST);
                    end else begin
                        tx_byte <= tx_byte;
                    end
                end
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        rr_ptr_r  <= (pick_idx_s == 3'd5) ? 3'd0 : pick_idx_s + 3'd1;
                        rd_region <= pick_idx_s;
                        rd_bank   <= region_first_bank(pick_idx_s);
                        rd_col    <= 7'd0;
                        tx_byte   <= CMD_SETY | {5'd0, region_first_bank(pick_idx_s)};
                        tx_dc     <= 1'b0;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_CMD_Y;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CMD_Y: begin
                    if (accept_s) begin
                        tx_byte <= CMD_SETX | {1'b0, region_x0(rd_region)};
                        state_r <= ST_CMD_X;
                    end else begin
                        tx_byte <= tx_byte;
                    end
                end
                ST_CMD_X: begin
                    if (accept_s) begin
                        tx_valid <= 1'b0;
                        state_r  <= ST_FETCH;
                    end else begin
                        tx_valid <= tx_valid;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_DATA;
                end
                ST_DATA: begin
                    // First DATA cycle captures the renderer byte; later cycles wait for accept.
                    if (!tx_valid) begin
                        tx_byte  <= rd_data;
                        tx_dc    <= 1'b1;
                        tx_valid <= 1'b1;
                    end else if (accept_s && (rd_col == region_width(rd_region) - 7'd1)) begin
                        if (rd_bank == region_last_bank(rd_region)) begin
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= ST_FIN;
                        end else begin
                            rd_bank <= rd_bank + 3'd1;
                            rd_col  <= 7'd0;
                            tx_byte <= CMD_SETY | {5'd0, rd_bank + 3'd1};
                            tx_dc   <= 1'b0;
                            state_r <= ST_CMD_Y;
                        end
                    end else if (accept_s) begin
                        tx_valid <= 1'b0;
                        rd_col   <= rd_col + 7'd1;
                        state_r  <= ST_FETCH;
                    end else begin
                        tx_valid <= tx_valid;
                    end
                end
                ST_FIN: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    tx_valid <= 1'b0;
                    state_r  <= ST_RST_PULSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_arbiter.sv
// Self-checking bench: scoreboard of expected LCD bytes compared at every
// handshake, plus per-scenario checks of reset, stall, ordering and done pulses.
module tb_lcd_refresh_arbiter;

    logic       clk = 1'b0;
    logic       rst1;
    logic [3:0] face_in;
    logic [2:0] food_lvl, sleep_lvl, fun_lvl, happy_lvl, health_lvl;
    logic [2:0] rd_region, rd_bank;
    logic [6:0] rd_col;
    logic [7:0] rd_data = 8'h00;
    logic       tx_valid, tx_ready, tx_dc, lcd_rst_n, busy, done;
    logic [7:0] tx_byte;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
        logic [2:0] region;
        logic [2:0] bank;
        logic [6:0] col;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    lcd_refresh_arbiter #(.RST_CYCLES(4), .CONTRAST(8'hB1), .REFRESH_TICKS(0)) dut (
        .clk(clk), .rst1(rst1), .face_in(face_in), .food_lvl(food_lvl),
        .sleep_lvl(sleep_lvl), .fun_lvl(fun_lvl), .happy_lvl(happy_lvl),
        .health_lvl(health_lvl), .rd_region(rd_region), .rd_bank(rd_bank),
        .rd_col(rd_col), .rd_data(rd_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_byte(tx_byte), .tx_dc(tx_dc), .lcd_rst_n(lcd_rst_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [2:0] r, input logic [2:0] b, input logic [6:0] c);
        return ({5'd0, r} * 8'd41) + ({5'd0, b} * 8'd17) + ({1'b0, c} * 8'd3);
    endfunction

    // Renderer model: one-cycle read latency.
    always @(posedge clk) rd_data <= pix(rd_region, rd_bank, rd_col);

    // Scoreboard: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst1 === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got dc=%0b byte=%02h rg=%0d bk=%0d col=%0d, required no byte",
                         tx_dc, tx_byte, rd_region, rd_bank, rd_col);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (tx_dc !== e.dc || tx_byte !== e.b ||
                    (e.dc && ({rd_region, rd_bank, rd_col} !== {e.region, e.bank, e.col}))) begin
                    errors++;
                    $display("FAIL sb_byte: got dc=%0b byte=%02h rg=%0d bk=%0d col=%0d, required dc=%0b byte=%02h rg=%0d bk=%0d col=%0d",
                             tx_dc, tx_byte, rd_region, rd_bank, rd_col, e.dc, e.b, e.region, e.bank, e.col);
                end
            end
        end
        if (rst1 === 1'b1 && done === 1'b1) done_cnt++;
    end

    task automatic push_init();
        logic [7:0] tbl [6];
        tbl = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, 8'h0C};
        for (int i = 0; i < 6; i++) sb_q.push_back('{1'b0, tbl[i], 3'd0, 3'd0, 7'd0});
    endtask

    task automatic push_region(input logic [2:0] r);
        int fb, lb, w;
        logic [7:0] x0;
        fb = (r == 3'd0) ? 0 : int'(r) - 1;
        lb = (r == 3'd0) ? 5 : int'(r) - 1;
        w  = (r == 3'd0) ? 48 : 36;
        x0 = (r == 3'd0) ? 8'd0 : 8'd48;
        for (int b = fb; b <= lb; b++) begin
            sb_q.push_back('{1'b0, 8'h40 | 8'(b), 3'd0, 3'd0, 7'd0});
            sb_q.push_back('{1'b0, 8'h80 | x0, 3'd0, 3'd0, 7'd0});
            for (int c = 0; c < w; c++)
                sb_q.push_back('{1'b1, pix(r, 3'(b), 7'(c)), r, 3'(b), 7'(c)});
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && busy === 1'b0 && done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        int lows;
        rst1 = 1'b0; tx_ready = 1'b1; face_in = 4'd0;
        food_lvl = 3'd0; sleep_lvl = 3'd0; fun_lvl = 3'd0; happy_lvl = 3'd0; health_lvl = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid, tx_byte, tx_dc, lcd_rst_n, busy, done} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctl: got v=%0b byte=%02h dc=%0b rstn=%0b busy=%0b done=%0b, required 0 00 0 0 1 0",
                     tx_valid, tx_byte, tx_dc, lcd_rst_n, busy, done);
        end
        checks++;
        if ({rd_region, rd_bank, rd_col} !== 13'd0) begin
            errors++;
            $display("FAIL reset_rd: got rg=%0d bk=%0d col=%0d, required 0 0 0", rd_region, rd_bank, rd_col);
        end
        push_init();
        for (int r = 0; r < 6; r++) push_region(3'(r));
        done_cnt = 0;
        @(posedge clk); #1 rst1 = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_rst_n === 1'b1) break;
            lows++;
        end
        checks++;
        if (lows != 4) begin
            errors++;
            $display("FAIL lcd_rst_len: got %0d low cycles, required 4", lows);
        end
        wait_idle(5000, ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL power_up_idle: got ok=%0b busy=%0b left=%0d, required ok=1 busy=0 left=0", ok, busy, sb_q.size());
        end
        checks++;
        if (done_cnt != 6) begin
            errors++;
            $display("FAIL power_up_done: got %0d pulses, required 6", done_cnt);
        end
    endtask

    task automatic test_single_change();
        bit ok;
        push_region(3'd1);
        @(posedge clk); #1 food_lvl = 3'd3;
        wait_idle(1000, ok);
        push_region(3'd1);
        done_cnt = 0;
        @(posedge clk); #1 food_lvl = 3'd4;
        wait_idle(1000, ok);
        checks++;
        if (!ok || done_cnt != 1) begin
            errors++;
            $display("FAIL food_redraw: got ok=%0b done=%0d left=%0d, required ok=1 done=1 left=0", ok, done_cnt, sb_q.size());
        end
    endtask

    task automatic test_rr_order();
        bit ok;
        push_region(3'd5);
        push_region(3'd0);
        done_cnt = 0;
        @(posedge clk); #1 face_in = 4'd5; health_lvl = 3'd2;
        wait_idle(3000, ok);
        checks++;
        if (!ok || done_cnt != 2) begin
            errors++;
            $display("FAIL rr_order: got ok=%0b done=%0d left=%0d, required ok=1 done=2 left=0", ok, done_cnt, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok, seen;
        push_region(3'd3);
        push_region(3'd3);
        done_cnt = 0;
        @(posedge clk); #1 fun_lvl = 3'd6;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = (rd_region === 3'd3 && tx_dc === 1'b1 && rd_col === 7'd5);
        end
        @(posedge clk); #1 fun_lvl = 3'd1;
        wait_idle(2000, ok);
        checks++;
        if (!seen || !ok || done_cnt != 2) begin
            errors++;
            $display("FAIL fun_twice: got seen=%0b ok=%0b done=%0d left=%0d, required 1 1 2 0", seen, ok, done_cnt, sb_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok, seen;
        logic [16:0] snap;
        push_region(3'd2);
        @(posedge clk); #1 sleep_lvl = 3'd7;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = (tx_valid === 1'b1 && tx_dc === 1'b1 && rd_col === 7'd10);
        end
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        snap = {tx_valid, tx_byte, tx_dc, rd_col};
        checks++;
        if (!seen || snap !== {1'b1, pix(3'd2, 3'd1, 7'd11), 1'b1, 7'd11}) begin
            errors++;
            $display("FAIL stall_load: got %05h seen=%0b, required %05h", snap, seen, {1'b1, pix(3'd2, 3'd1, 7'd11), 1'b1, 7'd11});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_valid, tx_byte, tx_dc, rd_col} !== snap) begin
                errors++;
                $display("FAIL stall_hold: got %05h, required %05h", {tx_valid, tx_byte, tx_dc, rd_col}, snap);
            end
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_idle(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_resume: got left=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bit ok, seen;
        push_region(3'd0);
        @(posedge clk); #1 face_in = 4'd9;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = (rd_region === 3'd0 && rd_bank === 3'd1 && tx_valid === 1'b1 && tx_dc === 1'b1);
        end
        #2 rst1 = 1'b0;
        #1;
        checks++;
        if (!seen || tx_valid !== 1'b0 || lcd_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got seen=%0b v=%0b rstn=%0b, required 1 0 0", seen, tx_valid, lcd_rst_n);
        end
        sb_q.delete();
        push_init();
        for (int r = 0; r < 6; r++) push_region(3'(r));
        repeat (2) @(posedge clk);
        done_cnt = 0;
        #1 rst1 = 1'b1;
        wait_idle(5000, ok);
        checks++;
        if (!ok || done_cnt != 6) begin
            errors++;
            $display("FAIL replay_init: got ok=%0b done=%0d left=%0d, required ok=1 done=6 left=0", ok, done_cnt, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_rr_order();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
